// File: rtl/ei_multiport_regbank.sv
// Multi-port register bank: round-robin host ports, per-register RW/RO/W1C, hw update port, change strobes.
// Optional write lock enabled by defining REGBANK_LOCK_EN.
module ei_multiport_regbank #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 64,
    parameter int NUM_PORTS  = 2,
    parameter int LOCK_ADDR  = 0,
    parameter logic [DATA_WIDTH-1:0] LOCK_KEY = DATA_WIDTH'('hA5),
    localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_DEPTH*DATA_WIDTH-1:0] init_values,
    input  logic [2*DATA_DEPTH-1:0]          mode_cfg,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             we,
    input  logic [NUM_PORTS*AW-1:0]          addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
    output logic [NUM_PORTS-1:0]             ack,
    output logic [NUM_PORTS-1:0]             err,
    output logic [DATA_WIDTH-1:0]            rdata,
    input  logic                             hw_we,
    input  logic [AW-1:0]                    hw_addr,
    input  logic [DATA_WIDTH-1:0]            hw_data,
    output logic [DATA_DEPTH*DATA_WIDTH-1:0] regs_flat,
    output logic [DATA_DEPTH-1:0]            changed
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [1:0] MODE_W1C = 2'b10;

    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [NUM_PORTS-1:0]  ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_DEPTH-1:0] changed_q, changed_d;
`ifdef REGBANK_LOCK_EN
    logic                  unlocked_q, unlocked_d;
`endif

    logic [NUM_PORTS-1:0]  cand;
    logic                  gnt_vld, g_we, hw_ok, hw_hit;
    int                    gnt_idx;
    logic [AW-1:0]         g_addr;
    logic [DATA_WIDTH-1:0] g_wdata, g_old, g_new;
    logic [1:0]            g_mode, hw_mode;

    always_comb begin
        regs_d    = regs_q;
        rr_d      = rr_q;
        ack_d     = '0;
        err_d     = '0;
        rdata_d   = '0;
        changed_d = '0;
`ifdef REGBANK_LOCK_EN
        unlocked_d = unlocked_q;
`endif
        // The port being acked this cycle is masked so it cannot be served twice.
        cand    = req & ~ack_q;
        gnt_vld = 1'b0;
        gnt_idx = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!gnt_vld && cand[(int'(rr_q) + k) % NUM_PORTS]) begin
                gnt_vld = 1'b1;
                gnt_idx = (int'(rr_q) + k) % NUM_PORTS;
            end
        end
        g_we    = we[gnt_idx];
        g_addr  = addr[gnt_idx*AW +: AW];
        g_wdata = wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        g_old   = '0;
        g_new   = '0;
        g_mode  = '0;
        hw_mode = '0;

        hw_ok = hw_we && (int'(hw_addr) < DATA_DEPTH);
`ifdef REGBANK_LOCK_EN
        hw_ok = hw_ok && (int'(hw_addr) != LOCK_ADDR);
`endif
        hw_hit = hw_ok && (hw_addr == g_addr);
        if (hw_ok) begin
            hw_mode = mode_cfg[2*int'(hw_addr) +: 2];
            regs_d[hw_addr] = (hw_mode == MODE_W1C) ? (regs_q[hw_addr] | hw_data) : hw_data;
        end

        if (gnt_vld) begin
            ack_d[gnt_idx] = 1'b1;
            rr_d = PW'((gnt_idx + 1) % NUM_PORTS);
            if (int'(g_addr) >= DATA_DEPTH) begin
                err_d[gnt_idx] = 1'b1;
`ifdef REGBANK_LOCK_EN
            end else if (int'(g_addr) == LOCK_ADDR) begin
                rdata_d = DATA_WIDTH'(unlocked_q);
                if (g_we) begin
                    unlocked_d        = (g_wdata == LOCK_KEY);
                    changed_d[g_addr] = (unlocked_d != unlocked_q);
                end
`endif
            end else begin
                g_mode  = mode_cfg[2*int'(g_addr) +: 2];
                g_old   = regs_q[g_addr];
                rdata_d = g_old;
                if (g_we) begin
`ifdef REGBANK_LOCK_EN
                    if (g_mode[0] || !unlocked_q) begin
`else
                    if (g_mode[0]) begin
`endif
                        err_d[gnt_idx] = 1'b1;
                    end else begin
                        g_new = (g_mode == MODE_W1C) ? (g_old & ~g_wdata) : g_wdata;
                        changed_d[g_addr] = (g_new != g_old);
                        // Host value overrides hw on RW; on W1C hw set bits survive the clear.
                        regs_d[g_addr] = (g_mode == MODE_W1C && hw_hit) ? (g_new | hw_data) : g_new;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= init_values;
            rr_q      <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '0;
            changed_q <= '0;
`ifdef REGBANK_LOCK_EN
            unlocked_q <= 1'b0;
`endif
        end else begin
            regs_q    <= regs_d;
            rr_q      <= rr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            changed_q <= changed_d;
`ifdef REGBANK_LOCK_EN
            unlocked_q <= unlocked_d;
`endif
        end
    end

    always_comb begin
        regs_flat = regs_q;
`ifdef REGBANK_LOCK_EN
        regs_flat[LOCK_ADDR*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(unlocked_q);
`endif
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_ei_multiport_regbank.sv
// Self-checking bench for ei_multiport_regbank: directed cases plus random traffic vs a register-map model.
module tb_ei_multiport_regbank;
    localparam int W  = 8;
    localparam int D  = 48;
    localparam int NP = 2;
    localparam int AW = 6;
    localparam int LA = 1;
`ifdef REGBANK_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [D*W-1:0]   init_values;
    logic [2*D-1:0]   mode_cfg;
    logic [NP-1:0]    req, we, ack, err;
    logic [NP*AW-1:0] addr;
    logic [NP*W-1:0]  wdata;
    logic [W-1:0]     rdata;
    logic             hw_we;
    logic [AW-1:0]    hw_addr;
    logic [W-1:0]     hw_data;
    logic [D*W-1:0]   regs_flat;
    logic [D-1:0]     changed;

    always #5 clk = ~clk;

    ei_multiport_regbank #(.DATA_WIDTH(W), .DATA_DEPTH(D), .NUM_PORTS(NP), .LOCK_ADDR(LA)) u_dut (
        .clk(clk), .rst(rst), .init_values(init_values), .mode_cfg(mode_cfg),
        .req(req), .we(we), .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
        .hw_we(hw_we), .hw_addr(hw_addr), .hw_data(hw_data), .regs_flat(regs_flat), .changed(changed)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register map: 0,1 -> RO, 2 -> W1C, 3 -> RW, repeating every four addresses.
    function automatic logic [1:0] mode_of(input int i);
        case (i % 4)
            0: return 2'b01;
            1: return 2'b11;
            2: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    logic [W-1:0]  m_regs [D];
    bit            m_unl;
    int            m_ptr;
    logic [NP-1:0] e_ack, e_err;
    logic [W-1:0]  e_rd;
    logic [D-1:0]  e_chg;

    function automatic logic [D*W-1:0] model_flat();
        logic [D*W-1:0] f;
        for (int i = 0; i < D; i++) f[i*W +: W] = m_regs[i];
        if (LOCK) f[LA*W +: W] = {7'b0, m_unl};
        return f;
    endfunction

    // Predict the next edge from the current inputs, clock it, then compare.
    task automatic step();
        logic [W-1:0]  nr [D];
        logic [NP-1:0] cand, n_ack, n_err;
        logic [W-1:0]  n_rd, wd, nv;
        logic [D-1:0]  n_chg;
        bit            n_unl, w, ro, w1c;
        int            g, a, ha;
        nr = m_regs; n_ack = '0; n_err = '0; n_rd = '0; n_chg = '0; n_unl = m_unl; g = -1;
        cand = req & ~e_ack;
        for (int k = 0; k < NP; k++)
            if (g < 0 && cand[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
        ha = int'(hw_addr);
        if (hw_we && ha < D && !(LOCK && ha == LA))
            nr[ha] = (mode_of(ha) == 2'b10) ? (m_regs[ha] | hw_data) : hw_data;
        if (g >= 0) begin
            a  = int'(addr[g*AW +: AW]);
            w  = we[g];
            wd = wdata[g*W +: W];
            n_ack[g] = 1'b1;
            m_ptr = (g + 1) % NP;
            if (a >= D) n_err[g] = 1'b1;
            else if (LOCK && a == LA) begin
                n_rd = {7'b0, m_unl};
                if (w) begin
                    n_unl = (wd == 8'hA5);
                    n_chg[a] = (n_unl != m_unl);
                end
            end else begin
                n_rd = m_regs[a];
                ro   = (mode_of(a) == 2'b01) || (mode_of(a) == 2'b11);
                w1c  = (mode_of(a) == 2'b10);
                if (w) begin
                    if (ro || (LOCK && !m_unl)) n_err[g] = 1'b1;
                    else begin
                        nv = w1c ? (m_regs[a] & ~wd) : wd;
                        n_chg[a] = (nv != m_regs[a]);
                        nr[a] = (w1c && hw_we && ha == a) ? (nv | hw_data) : nv;
                    end
                end
            end
        end
        @(posedge clk); #1;
        m_regs = nr; m_unl = n_unl; e_ack = n_ack; e_err = n_err; e_rd = n_rd; e_chg = n_chg;
        chk("ack", ack, e_ack);
        chk("changed", changed, e_chg);
        chk("regs", regs_flat, model_flat());
        if (|e_ack) begin
            chk("err", err, e_err);
            chk("rdata", rdata, e_rd);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; hw_we = 1'b0; hw_addr = '0; hw_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < D; i++) m_regs[i] = init_values[i*W +: W];
        m_unl = 1'b0; m_ptr = 0; e_ack = '0; e_err = '0; e_rd = '0; e_chg = '0;
        chk("rst_ack", ack, '0);
        chk("rst_changed", changed, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_regs", regs_flat, model_flat());
    endtask

    // Single host transaction; the optional hw update lands on the grant edge.
    task automatic txn(input int p, input bit w, input int a, input logic [W-1:0] wd,
                       input bit hw = 1'b0, input int ha = 0, input logic [W-1:0] hd = '0);
        if (e_ack[p]) step();
        req[p] = 1'b1; we[p] = w; addr[p*AW +: AW] = AW'(a); wdata[p*W +: W] = wd;
        hw_we = hw; hw_addr = AW'(ha); hw_data = hd;
        for (int i = 0; i < 20; i++) begin
            step();
            hw_we = 1'b0;
            if (ack[p]) break;
        end
        chk("txn_ack", ack[p], 1'b1);
        req[p] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            init_values[i*W +: W] = W'(8'h10 + i);
            mode_cfg[2*i +: 2]    = mode_of(i);
        end
        do_reset();

        // Read after reset
        chk("t1_reg5", regs_flat[5*W +: W], 8'h15);
        txn(0, 1'b0, 5, 8'h00);
        chk("t1_rdata", rdata, 8'h15);
        chk("t1_err", err[0], 1'b0);

`ifdef REGBANK_LOCK_EN
        txn(0, 1'b1, 3, 8'h77);
        chk("lk_locked_err", err[0], 1'b1);
        txn(1, 1'b1, LA, 8'hA5);
        chk("lk_unlock_err", err[1], 1'b0);
        txn(0, 1'b1, 3, 8'h77);
        chk("lk_retry_err", err[0], 1'b0);
        chk("lk_retry_val", regs_flat[3*W +: W], 8'h77);
        txn(0, 1'b1, LA, 8'h00);
        txn(0, 1'b1, 3, 8'h11);
        chk("lk_relock_err", err[0], 1'b1);
        txn(0, 1'b1, LA, 8'hA5);
`endif

        // RW write with and without a value change
        txn(0, 1'b1, 3, 8'h3C);
        chk("t2_chg", changed[3], 1'b1);
        chk("t2_val", regs_flat[3*W +: W], 8'h3C);
        txn(0, 1'b1, 3, 8'h3C);
        chk("t2_nochg", changed[3], 1'b0);
        chk("t2_err", err[0], 1'b0);

        // Errors and W1C
        txn(0, 1'b1, 0, 8'hFF);
        chk("t4_ro_err", err[0], 1'b1);
        chk("t4_ro_val", regs_flat[0 +: W], 8'h10);
        txn(1, 1'b0, 50, 8'h00);
        chk("t4_oor_err", err[1], 1'b1);
        chk("t4_oor_rd", rdata, 8'h00);
        txn(0, 1'b1, 6, 8'hFF);
        hw_we = 1'b1; hw_addr = 6'd6; hw_data = 8'hF0;
        step();
        hw_we = 1'b0;
        txn(0, 1'b1, 6, 8'h30);
        chk("t4_w1c", regs_flat[6*W +: W], 8'hC0);

        // Same-edge host + hw on one register
        txn(0, 1'b1, 2, 8'hFF);
        hw_we = 1'b1; hw_addr = 6'd2; hw_data = 8'h0F;
        step();
        hw_we = 1'b0;
        txn(0, 1'b1, 2, 8'h0F, 1'b1, 2, 8'h01);
        chk("t5_w1c_hw", regs_flat[2*W +: W], 8'h01);
        txn(1, 1'b1, 3, 8'h55, 1'b1, 3, 8'hAA);
        chk("t5_rw_host", regs_flat[3*W +: W], 8'h55);

        // Both ports requesting continuously alternate 0,1,0,1
        do_reset();
        req = 2'b11; we = 2'b00; addr = {6'd7, 6'd5};
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_rr", ack, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        req = '0;
        step();
        step();

        // Random traffic from both ports plus hw updates
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (ack[p] || !req[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[p] = 1'b1;
                        we[p]  = 1'($urandom_range(0, 1));
                        addr[p*AW +: AW] = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(48, 63))
                                                                         : AW'($urandom_range(0, 11));
                        wdata[p*W +: W] = W'($urandom);
                    end else req[p] = 1'b0;
                end
            end
            hw_we   = ($urandom_range(0, 2) == 0);
            hw_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(48, 63)) : AW'($urandom_range(0, 11));
            hw_data = W'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
